// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared types and constants for the data-memory responder
//               and the CPU top that talks to it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } dmem_state_e;

  localparam int          WORD_W           = 64;
  localparam int          ADDR_CLAMP_LIMIT = 8200;
  localparam logic [6:0]  NOP_OPCODE       = 7'b0010011;
  localparam logic [6:0]  HALT_OPCODE      = 7'b0000000;

  // CPU-side address clamp: anything above the limit collapses to 0.
  function automatic logic [31:0] cpu_clamp_addr(input logic [31:0] addr);
    return (addr > 32'(ADDR_CLAMP_LIMIT)) ? 32'd0 : addr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module      : dmem_responder_if
// Description : Valid/ready memory-image dump port of the data-memory
//               responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_responder_if #(
  parameter int DEPTH = 1024
) ();

  logic                     dump_valid;
  logic                     dump_ready;
  logic [$clog2(DEPTH)-1:0] dump_index;
  logic [63:0]              dump_data;
  logic                     dump_last;
  logic                     dump_done;

  modport master (
    output dump_valid, dump_index, dump_data, dump_last, dump_done,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_index, dump_data, dump_last, dump_done,
    output dump_ready
  );

endinterface

`default_nettype wire

// File: rtl/dmem_dump_ctrl.sv
// ============================================================================
// Module      : dmem_dump_ctrl
// Description : RUN/DRAIN/DUMP/DONE sequencer, dump pointer and dump
//               handshake for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_dump_ctrl
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int DUMP_BASE = 0
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     halt,
  input  wire logic                     dump_ready,
  output dmem_state_e                   state,
  output logic                          dump_valid,
  output logic [$clog2(DEPTH)-1:0]      dump_index,
  output logic                          dump_last,
  output logic                          dump_done
);

  localparam int                 IDX_W  = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]   c_last = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]   c_base = IDX_W'(DUMP_BASE);

  dmem_state_e       r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic              r_valid;
  logic [IDX_W-1:0]  r_index;
  logic              r_last;
  logic              r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_ptr   <= c_base;
      r_valid <= 1'b0;
      r_index <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_state <= ST_DUMP;
          r_valid <= 1'b1;
          r_index <= r_ptr;
          r_last  <= (r_ptr == c_last);
        end
        ST_DUMP: begin
          if (r_valid && dump_ready) begin
            if (r_last) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_ptr   <= r_ptr + 1'b1;
              r_index <= r_ptr + 1'b1;
              r_last  <= ((r_ptr + 1'b1) == c_last);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign state      = r_state;
  assign dump_valid = r_valid;
  assign dump_index = r_index;
  assign dump_last  = r_last;
  assign dump_done  = r_done;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : MEM-stage data memory: async loads onto a shared tri-state
//               bus, clocked stores, post-halt image dump. Optional store
//               counter enabled by DMEM_STORE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 32,
  parameter int DUMP_BASE = 0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [ADDR_W-1:0] mem_addr,
  input  wire logic              mem_rw,
  inout  wire [WORD_W-1:0]       mem_data,
  input  wire logic              halt,
  dmem_responder_if.master       dump,
  output logic                   addr_err
`ifdef DMEM_STORE_COUNT_EN
  ,
  output logic [31:0]            store_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  if (DUMP_BASE >= DEPTH) begin : g_bad_dump_base
    $fatal(1, "dmem_responder: DUMP_BASE must be below DEPTH");
  end

  logic [WORD_W-1:0] r_mem [DEPTH];

  dmem_state_e       w_state;
  logic              w_run;
  logic [ADDR_W-1:0] w_word_full;
  logic [IDX_W-1:0]  w_idx;
  logic              w_idx_valid;
  logic              w_aligned;
  logic              w_store;
  logic              w_bus_oe;
  logic [WORD_W-1:0] w_rd_data;
  logic              w_dump_valid;
  logic [IDX_W-1:0]  w_dump_index;
  logic              w_dump_last;
  logic              w_dump_done;
  logic              r_addr_err;

  assign w_run       = (w_state == ST_RUN);
  assign w_word_full = mem_addr >> 3;
  assign w_idx_valid = (w_word_full < ADDR_W'(DEPTH));
  assign w_idx       = w_word_full[IDX_W-1:0];
  assign w_aligned   = (mem_addr[2:0] == 3'b000);
  assign w_store     = w_run && !rst && mem_rw && w_idx_valid && w_aligned;
  // Bus released while in reset so the reset cycle itself shows Z.
  assign w_bus_oe    = w_run && !rst && !mem_rw;
  assign w_rd_data   = w_idx_valid ? r_mem[w_idx] : '0;
  assign mem_data    = w_bus_oe ? w_rd_data : 'z;

  always_ff @(posedge clk) begin
    if (w_store) r_mem[w_idx] <= mem_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else if (w_run && (!w_aligned || (mem_rw && !w_idx_valid))) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err = r_addr_err;

  dmem_dump_ctrl #(
    .DEPTH     (DEPTH),
    .DUMP_BASE (DUMP_BASE)
  ) u_dump_ctrl (
    .clk        (clk),
    .rst        (rst),
    .halt       (halt),
    .dump_ready (dump.dump_ready),
    .state      (w_state),
    .dump_valid (w_dump_valid),
    .dump_index (w_dump_index),
    .dump_last  (w_dump_last),
    .dump_done  (w_dump_done)
  );

  // The array is frozen outside RUN, so an async read of the pointer is stable.
  assign dump.dump_valid = w_dump_valid;
  assign dump.dump_index = w_dump_index;
  assign dump.dump_data  = w_dump_valid ? r_mem[w_dump_index] : '0;
  assign dump.dump_last  = w_dump_last;
  assign dump.dump_done  = w_dump_done;

`ifdef DMEM_STORE_COUNT_EN
  logic [31:0] r_store_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_store_cnt <= '0;
    end else if (w_store && (r_store_cnt != 32'hFFFF_FFFF)) begin
      r_store_cnt <= r_store_cnt + 32'd1;
    end
  end

  assign store_cnt = r_store_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam logic [63:0] c_word_a = 64'h1111_2222_3333_4444;
  localparam logic [63:0] c_word_b = 64'hBAD0_BAD0_BAD0_BAD0;
  localparam logic [63:0] c_word_s = 64'hDEAD_BEEF_0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic        mem_rw = 1'b0;
  logic [63:0] wdata = '0;
  logic        halt = 1'b0;
  logic        addr_err;
  wire  [63:0] mem_data;
`ifdef DMEM_STORE_COUNT_EN
  logic [31:0] store_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  dmem_responder_if #(.DEPTH(1024)) dif ();

  assign mem_data = mem_rw ? wdata : 64'hz;

  dmem_responder #(
    .DEPTH     (1024),
    .ADDR_W    (32),
    .DUMP_BASE (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_rw   (mem_rw),
    .mem_data (mem_data),
    .halt     (halt),
    .dump     (dif.master),
    .addr_err (addr_err)
`ifdef DMEM_STORE_COUNT_EN
    ,
    .store_cnt(store_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0]  idx_before;
    logic [63:0] data_before;
    logic [63:0] dump_w1;
    logic [63:0] dump_w2;
    int          beats;
    int          last_beats;
    logic        stable_ok;
    logic        last_ok;

    dif.dump_ready = 1'b0;

    // Reset state, bus released during the reset cycle
    tick();
    chk("rst_oe",         64'(dut.w_bus_oe),    64'd0);
    chk("rst_dump_valid", 64'(dif.dump_valid),  64'd0);
    chk("rst_dump_done",  64'(dif.dump_done),   64'd0);
    chk("rst_dump_last",  64'(dif.dump_last),   64'd0);
    chk("rst_dump_index", 64'(dif.dump_index),  64'd0);
    chk("rst_dump_data",  dif.dump_data,        64'd0);
    chk("rst_addr_err",   64'(addr_err),        64'd0);
    rst = 1'b0;

    // Store then load at byte 16
    mem_rw = 1'b1; mem_addr = 32'd16; wdata = c_word_s;
    #1 chk("store_oe", 64'(dut.w_bus_oe), 64'd0);
    tick();
    mem_rw = 1'b0; mem_addr = 32'd16;
    #1 chk("load16", mem_data, c_word_s);
    chk("load16_err", 64'(addr_err), 64'd0);

    // Known word at index 1, then out-of-range store that aliases to index 1
    mem_rw = 1'b1; mem_addr = 32'd8; wdata = c_word_a;
    tick();
    mem_rw = 1'b1; mem_addr = 32'd8200; wdata = c_word_b;
    tick();
    mem_rw = 1'b0; mem_addr = 32'd8;
    #1 chk("oor_err", 64'(addr_err), 64'd1);
    chk("oor_word1", mem_data, c_word_a);
    mem_addr = 32'd8200;
    #1 chk("oor_load", mem_data, 64'd0);
    tick();
    chk("oor_err_sticky", 64'(addr_err), 64'd1);
`ifdef DMEM_STORE_COUNT_EN
    chk("store_cnt_2", 64'(store_cnt), 64'd2);
`endif

    // Misaligned store after a reset (array retained)
    mem_addr = 32'd8; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mis_err_clr", 64'(addr_err), 64'd0);
    mem_rw = 1'b1; mem_addr = 32'd12; wdata = 64'd5;
    tick();
    mem_rw = 1'b0; mem_addr = 32'd8;
    #1 chk("mis_st_err", 64'(addr_err), 64'd1);
    chk("mis_st_word1", mem_data, c_word_a);

    // Misaligned load sets the flag but still serves the word
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("misld_err_clr", 64'(addr_err), 64'd0);
    mem_addr = 32'd20;
    tick();
    mem_addr = 32'd16;
    #1 chk("misld_err", 64'(addr_err), 64'd1);
    chk("misld_word2", mem_data, c_word_s);

    // Halt coincident with a store of 7 to word 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rw = 1'b1; mem_addr = 32'd0; wdata = 64'd7; halt = 1'b1;
    tick();
    mem_rw = 1'b0; halt = 1'b0;
    #1 chk("drain_oe", 64'(dut.w_bus_oe), 64'd0);
    chk("drain_valid", 64'(dif.dump_valid), 64'd0);
    tick();
    chk("dump_oe", 64'(dut.w_bus_oe), 64'd0);
    chk("dump_first_valid", 64'(dif.dump_valid), 64'd1);
    chk("dump_first_index", 64'(dif.dump_index), 64'd0);
    chk("dump_first_data",  dif.dump_data, 64'd7);
    chk("dump_first_last",  64'(dif.dump_last), 64'd0);

    // Full dump with ready toggling every cycle
    beats = 0; last_beats = 0; stable_ok = 1'b1; last_ok = 1'b1;
    dump_w1 = '0; dump_w2 = '0;
    for (int c = 0; c < 4000 && dif.dump_valid; c++) begin
      dif.dump_ready = ((c % 2) == 0);
      idx_before  = dif.dump_index;
      data_before = dif.dump_data;
      if (dif.dump_last !== (idx_before == 10'd1023)) last_ok = 1'b0;
      if (idx_before == 10'd1) dump_w1 = data_before;
      if (idx_before == 10'd2) dump_w2 = data_before;
      if (dif.dump_ready && dif.dump_last) last_beats++;
      tick();
      if (dif.dump_ready) begin
        beats++;
      end else if (dif.dump_valid !== 1'b1 || dif.dump_index !== idx_before ||
                   dif.dump_data !== data_before) begin
        stable_ok = 1'b0;
      end
    end
    dif.dump_ready = 1'b0;
    chk("dump_beats",      64'(beats),          64'd1024);
    chk("dump_last_beats", 64'(last_beats),     64'd1);
    chk("dump_stable",     64'(stable_ok),      64'd1);
    chk("dump_last_only",  64'(last_ok),        64'd1);
    chk("dump_word1",      dump_w1,             c_word_a);
    chk("dump_word2",      dump_w2,             c_word_s);
    chk("done_valid",      64'(dif.dump_valid), 64'd0);
    chk("done_flag",       64'(dif.dump_done),  64'd1);
    halt = 1'b1;
    tick();
    tick();
    halt = 1'b0;
    chk("done_sticky",     64'(dif.dump_done),  64'd1);
    chk("done_oe",         64'(dut.w_bus_oe),   64'd0);

    // Reset in the middle of a second dump
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("redump_done_clr", 64'(dif.dump_done), 64'd0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    dif.dump_ready = 1'b1;
    for (int c = 0; c < 100 && dif.dump_index != 10'd37; c++) tick();
    chk("abort_at_37", 64'(dif.dump_index), 64'd37);
    rst = 1'b1; dif.dump_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort_run",   64'(dut.w_run),      64'd1);
    chk("abort_valid", 64'(dif.dump_valid), 64'd0);
    chk("abort_done",  64'(dif.dump_done),  64'd0);
    mem_rw = 1'b0; mem_addr = 32'd0;
    #1 chk("abort_load0", mem_data, 64'd7);
    chk("abort_oe", 64'(dut.w_bus_oe), 64'd1);
`ifdef DMEM_STORE_COUNT_EN
    chk("store_cnt_rst", 64'(store_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
